// File: rtl/mem_bist_ctrl_pkg.sv
// Shared types and defaults for the memory BIST controller.
package mem_bist_ctrl_pkg;

  localparam logic [7:0] DEF_SEED  = 8'hA5;
  localparam int         DEF_ERR_W = 4;

  // Test phases in execution order. FIN is the drain cycle for the last compare.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR0  = 3'd1,
    ST_RD0  = 3'd2,
    ST_WR1  = 3'd3,
    ST_RD1  = 3'd4,
    ST_FIN  = 3'd5
  } bist_state_e;

  // Phase that follows the last address of an access phase.
  function automatic bist_state_e next_phase(input bist_state_e s);
    case (s)
      ST_WR0:  return ST_RD0;
      ST_RD0:  return ST_WR1;
      ST_WR1:  return ST_RD1;
      ST_RD1:  return ST_FIN;
      default: return ST_IDLE;
    endcase
  endfunction

  // States that drive a RAM command.
  function automatic logic is_access(input bist_state_e s);
    return (s == ST_WR0) || (s == ST_RD0) || (s == ST_WR1) || (s == ST_RD1);
  endfunction

  function automatic logic is_write(input bist_state_e s);
    return (s == ST_WR0) || (s == ST_WR1);
  endfunction

  // Second pass uses the inverted pattern.
  function automatic logic is_inv(input bist_state_e s);
    return (s == ST_WR1) || (s == ST_RD1);
  endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-data compare and error logging. A read issued in cycle t is registered
// here (addr, expected) and checked against dout in cycle t+1, regardless of
// what the controller FSM is doing by then.
module mem_bist_cmp
  import mem_bist_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] expected,
  input  logic [DATA_W-1:0] dout,
  output logic              mismatch,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [DATA_W-1:0] fd_q, fd_d;

  // Next-state: capture the pending read, count mismatches, log the first one.
  always_comb begin
    mismatch = vld_q && (dout != exp_q);
    vld_d    = valid;
    addr_d   = addr;
    exp_d    = expected;
    err_d    = err_q;
    fa_d     = fa_q;
    fd_d     = fd_q;
    if (clear) begin
      err_d = '0;
      fa_d  = '0;
      fd_d  = '0;
    end else if (mismatch) begin
      // err_q never returns to zero within a run, so zero marks the first miss.
      if (err_q == '0) begin
        fa_d = addr_q;
        fd_d = dout;
      end
      if (err_q != '1) begin
        err_d = err_q + 1'b1;
      end
    end
  end

  // Registers; reset invalidates the pending compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      exp_q  <= '0;
      err_q  <= '0;
      fa_q   <= '0;
      fd_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      exp_q  <= exp_d;
      err_q  <= err_d;
      fa_q   <= fa_d;
      fd_q   <= fd_d;
    end
  end

  assign err_cnt   = err_q;
  assign fail_addr = fa_q;
  assign fail_data = fd_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-style BIST controller for a single-port synchronous RAM: write
// SEED^a, read it back, write ~(SEED^a), read it back, one address per cycle.
//
// Handshake: start is sampled only while the FSM is IDLE (busy=0); a run then
// proceeds without back-pressure. done is a one-cycle pulse on return to IDLE,
// and pass/fail_addr/fail_data/err_cnt stay stable until the next accepted start.
// All RAM command outputs (en/we/addr/din) are registered.
module mem_bist_ctrl
  import mem_bist_ctrl_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 3,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEF_SEED),
  parameter int                ERR_W  = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              en,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [2:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              clear;
  logic              mismatch;

  // Test pattern for address a; the address is zero-extended to DATA_W.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic inv);
    logic [DATA_W-1:0] p;
    p = SEED ^ DATA_W'(a);
    return inv ? ~p : p;
  endfunction

  // Next-state and next-command decode; outputs derive from the next state so
  // they land in the same cycle as the state they belong to.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WR0;
          addr_d  = '0;
          pass_d  = 1'b0;
          clear   = 1'b1;
        end
      end
      ST_WR0, ST_RD0, ST_WR1, ST_RD1: begin
        // Counter wraps to 0 exactly at the phase change: no gap cycles.
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = next_phase(state_q);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        addr_d  = '0;
        done_d  = 1'b1;
        // The final RD1 compare resolves in this cycle; fold it in.
        pass_d  = (err_cnt == '0) && !mismatch;
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
    endcase
    en_d   = is_access(state_d);
    we_d   = is_write(state_d);
    exp_d  = pattern(addr_d, is_inv(state_d));
    din_d  = we_d ? exp_d : '0;
    busy_d = (state_d != ST_IDLE);
  end

  // Single state/output register bank for the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      din_q   <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      we_q    <= we_d;
      din_q   <= din_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  mem_bist_cmp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .ERR_W  (ERR_W)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .valid     (en_q && !we_q),
    .addr      (addr_q),
    .expected  (exp_q),
    .dout      (dout),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

  assign en        = en_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign din       = din_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign dbg_state = state_q;

endmodule
